// File: rtl/counter_mode_scheduler_pkg.sv
// rtl/counter_mode_scheduler_pkg.sv - shared encodings and types for the counter mode scheduler
package counter_mode_scheduler_pkg;

    typedef enum logic [1:0] {
        MODE_MOD9  = 2'd0,
        MODE_MOD11 = 2'd1,
        MODE_MOD13 = 2'd2,
        MODE_MOD15 = 2'd3
    } cnt_mode_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_RUN  = 2'd2,
        ST_DONE = 2'd3
    } sched_state_e;

    localparam int SCHED_REP_W = 4;

    typedef struct packed {
        logic [1:0]             mode;
        logic [SCHED_REP_W-1:0] reps;
    } sched_entry_t;

    // Modulus 9/11/13/15 and terminal value 8/10/12/14 follow directly from the mode bits.
    function automatic logic [3:0] modulus_of(input logic [1:0] m);
        return {1'b1, m, 1'b1};
    endfunction

    function automatic logic [3:0] term_of(input logic [1:0] m);
        return {1'b1, m, 1'b0};
    endfunction

endpackage

// File: rtl/counter_mode_scheduler_if.sv
// rtl/counter_mode_scheduler_if.sv - config, run control and counter-side signals of the scheduler
interface counter_mode_scheduler_if #(
    parameter int AW    = 2,
    parameter int REP_W = 4
);
    logic             cfg_we;
    logic [AW-1:0]    cfg_addr;
    logic [1:0]       cfg_mode;
    logic [REP_W-1:0] cfg_reps;
    logic             start;
    logic [AW:0]      start_len;
    logic             abort;
    logic             cnt_step;
    logic [3:0]       cnt_out;
    logic [1:0]       mode;
    logic             cnt_clr;
    logic             busy;
    logic             done;
    logic             aborted;
    logic             err;

    modport master (
        output cfg_we, cfg_addr, cfg_mode, cfg_reps, start, start_len, abort, cnt_step, cnt_out,
        input  mode, cnt_clr, busy, done, aborted, err
    );

    modport slave (
        input  cfg_we, cfg_addr, cfg_mode, cfg_reps, start, start_len, abort, cnt_step, cnt_out,
        output mode, cnt_clr, busy, done, aborted, err
    );
endinterface

// File: rtl/counter_mode_scheduler_table.sv
// rtl/counter_mode_scheduler_table.sv - schedule register file, synchronous write, combinational read
module counter_mode_scheduler_table #(
    parameter int DEPTH = 4,
    parameter int AW    = 2,
    parameter int REP_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_we,
    input  logic [AW-1:0]    i_waddr,
    input  logic [1:0]       i_wmode,
    input  logic [REP_W-1:0] i_wreps,
    input  logic [AW-1:0]    i_raddr,
    output logic [1:0]       o_rmode,
    output logic [REP_W-1:0] o_rreps
);
    logic [1:0]       r_mode [DEPTH];
    logic [REP_W-1:0] r_reps [DEPTH];

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mode[i] <= '0;
                r_reps[i] <= '0;
            end
        end else if (i_we) begin
            r_mode[i_waddr] <= i_wmode;
            r_reps[i_waddr] <= i_wreps;
        end
    end

    assign o_rmode = r_mode[i_raddr];
    assign o_rreps = r_reps[i_raddr];
endmodule

// File: rtl/counter_mode_scheduler.sv
// rtl/counter_mode_scheduler.sv - steps the modulo counter through a table of (mode, repeat) entries
module counter_mode_scheduler
    import counter_mode_scheduler_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int REP_W = 4,
    parameter int AW    = 2
) (
    input  logic clk,
    input  logic reset,
    counter_mode_scheduler_if.slave bus
);
    localparam logic [AW:0] DEPTH_L = (AW+1)'(DEPTH);

    sched_state_e     r_state, w_state_nxt;
    logic [1:0]       r_mode;
    logic [AW-1:0]    r_idx;
    logic [REP_W-1:0] r_wrap;
    logic [REP_W-1:0] r_reps;
    logic [AW:0]      r_len;
    logic             r_err;
    logic             r_zero_done;
    logic             r_abort_pulse;

    logic             w_tbl_we;
    logic [AW-1:0]    w_raddr;
    logic [1:0]       w_tbl_mode;
    logic [REP_W-1:0] w_tbl_reps;
    logic [REP_W-1:0] w_reps_eff;
    logic [AW:0]      w_len_clamped;
    logic             w_wrap, w_oor, w_last_rep, w_last_entry;
    logic             w_go, w_zero, w_load, w_advance, w_inc_wrap, w_abort;

    assign w_tbl_we = bus.cfg_we && (r_state == ST_IDLE);
    // In LOAD the read port fetches entry 0; otherwise it pre-fetches the next entry.
    assign w_raddr  = (r_state == ST_LOAD) ? '0 : r_idx + AW'(1);

    counter_mode_scheduler_table #(.DEPTH(DEPTH), .AW(AW), .REP_W(REP_W)) u_table (
        .clk     (clk),
        .reset   (reset),
        .i_we    (w_tbl_we),
        .i_waddr (bus.cfg_addr),
        .i_wmode (bus.cfg_mode),
        .i_wreps (bus.cfg_reps),
        .i_raddr (w_raddr),
        .o_rmode (w_tbl_mode),
        .o_rreps (w_tbl_reps)
    );

    assign w_wrap        = bus.cnt_step && (bus.cnt_out == term_of(r_mode));
    assign w_oor         = (r_state == ST_RUN) && bus.cnt_step && (bus.cnt_out > term_of(r_mode));
    assign w_reps_eff    = (r_reps == '0) ? REP_W'(1) : r_reps;
    assign w_last_rep    = ({1'b0, r_wrap} + (REP_W+1)'(1)) >= {1'b0, w_reps_eff};
    assign w_last_entry  = ({1'b0, r_idx} + (AW+1)'(1)) >= r_len;
    assign w_len_clamped = (bus.start_len > DEPTH_L) ? DEPTH_L : bus.start_len;

    always_ff @(posedge clk) begin
        if (reset) r_state <= ST_IDLE;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_go        = 1'b0;
        w_zero      = 1'b0;
        w_load      = 1'b0;
        w_advance   = 1'b0;
        w_inc_wrap  = 1'b0;
        w_abort     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (bus.start) begin
                    if (bus.start_len == '0) begin
                        w_zero = 1'b1;
                    end else begin
                        w_go        = 1'b1;
                        w_state_nxt = ST_LOAD;
                    end
                end
            end
            ST_LOAD: begin
                if (bus.abort) begin
                    w_abort     = 1'b1;
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_load      = 1'b1;
                    w_state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                if (bus.abort) begin
                    w_abort     = 1'b1;
                    w_state_nxt = ST_IDLE;
                end else if (w_wrap) begin
                    if (!w_last_rep)        w_inc_wrap  = 1'b1;
                    else if (!w_last_entry) w_advance   = 1'b1;
                    else                    w_state_nxt = ST_DONE;
                end
            end
            ST_DONE: w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_mode        <= '0;
            r_idx         <= '0;
            r_wrap        <= '0;
            r_reps        <= '0;
            r_len         <= '0;
            r_err         <= 1'b0;
            r_zero_done   <= 1'b0;
            r_abort_pulse <= 1'b0;
        end else begin
            r_zero_done   <= w_zero;
            r_abort_pulse <= w_abort;
            if (w_go) begin
                r_len <= w_len_clamped;
                r_err <= 1'b0;
            end else if (w_oor) begin
                r_err <= 1'b1;
            end
            // Mode changes only here, on the edge that samples a period boundary.
            if (w_load || w_advance) begin
                r_mode <= w_tbl_mode;
                r_reps <= w_tbl_reps;
                r_wrap <= '0;
                r_idx  <= w_load ? '0 : r_idx + AW'(1);
            end else if (w_inc_wrap) begin
                r_wrap <= r_wrap + REP_W'(1);
            end
        end
    end

    assign bus.mode    = r_mode;
    assign bus.cnt_clr = (r_state == ST_LOAD) || r_abort_pulse;
    assign bus.busy    = (r_state == ST_LOAD) || (r_state == ST_RUN);
    assign bus.done    = (r_state == ST_DONE) || r_zero_done;
    assign bus.aborted = r_abort_pulse;
    assign bus.err     = r_err;
endmodule
